// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 8-digit seven-segment scan driver.
//   NUM_DIGITS   - number of multiplexed digits
//   SEG_BLANK    - SEG value with every segment (and DP) dark
//   AN_OFF       - AN value with every anode off
//   SEG_PATTERNS - active-low g..a patterns for hex digits 0..F
//   digit_idx_t  - 3-bit digit index
//   msb_nibble() - index of the most-significant nonzero nibble (0 when all zero)
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Bit order g,f,e,d,c,b,a; 0 = segment lit.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [2:0] digit_idx_t;

  function automatic digit_idx_t msb_nibble(logic [31:0] word);
    digit_idx_t msb;
    msb = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (word[4*i +: 4] != 4'h0) msb = digit_idx_t'(i);
    end
    return msb;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to seven-segment pattern.
//   nibble_i - 4-bit hex value
//   seg_o    - active-low segments, bit order g,f,e,d,c,b,a
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_PATTERNS[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes a shadowed 32-bit hex word onto an 8-digit
// common-anode seven-segment display.
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   load      - captures data_in / dp_in into the shadow registers
//   data_in   - hex word, nibble i drives digit i (digit 0 rightmost)
//   dp_in     - decimal-point request per digit, 1 = lit
//   digit_en  - live per-digit enable, 1 = digit may light
//   SEG       - active-low segments, bit7 = DP, bits6..0 = g..a (registered)
//   AN        - active-low one-hot anodes (registered)
//   scan_idx  - digit currently being scanned
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero shadow nibble (digit 0 and DP-lit digits excepted).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic [2:0]  scan_idx
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       dp_q, dp_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic [3:0]       cur_nibble;
  logic [6:0]       cur_pattern;
  logic             slot_lit;

  // Refresh counter and digit index; the index simply rolls over 7 -> 0.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Shadow copy; a load leaves the scan timing untouched.
  always_comb begin
    data_d = data_q;
    dp_d   = dp_q;
    if (load) begin
      data_d = data_in;
      dp_d   = dp_in;
    end
  end

  always_comb begin
    cur_nibble = data_q[{idx_q, 2'b00} +: 4];
  end

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_pattern)
  );

  always_comb begin
    slot_lit = digit_en[idx_q];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit 0 always satisfies idx <= msb, so a zero word still shows "0".
    if ((idx_q > msb_nibble(data_q)) && !dp_q[idx_q]) begin
      slot_lit = 1'b0;
    end
`endif
  end

  // Blanked slots still consume their dwell time so brightness stays uniform.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (slot_lit) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = {~dp_q[idx_q], cur_pattern};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      dp_q   <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign AN       = an_q;
  assign SEG      = seg_q;
  assign scan_idx = idx_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage of the board top level.
- Consumes a 32-bit word and an 8-bit decimal-point mask, typically a PC, a register value or switch-selected debug data from the pipeline CPU.
- Time-multiplexes the word onto the 8-digit common-anode seven-segment display through the SEG and AN outputs.
- Holds a load-strobed shadow copy, so the CPU side may update the word asynchronously to the scan.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays lit. Minimum 2. The bench uses 4.
- CNT_W, 17: refresh counter width. Must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  in  1: system clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- load  in  1: capture strobe for data_in and dp_in.
- data_in  in  32: hex value; nibble i drives digit i, where digit 0 is the rightmost.
- dp_in  in  8: decimal-point request per digit, 1 = lit.
- digit_en  in  8: per-digit enable, 1 = digit may light. Sampled live, not shadowed.
- SEG  out  8: active-low segments. Bit7 = DP, bits6..0 = g,f,e,d,c,b,a.
- AN  out  8: active-low one-hot digit anodes.
- scan_idx  out  3: index of the digit currently driven, for debug.

Behaviour:
- Reset (async assert, sync release to the clock edge):
  - refresh counter = 0, scan_idx = 0
  - shadow data = 0, shadow dp = 0
  - AN = 8'hFF, SEG = 8'hFF
- Refresh counter:
  - Increments every clk.
  - At SCAN_DIV-1 it wraps to 0 and scan_idx increments.
  - scan_idx wraps 7 -> 0; there is no idle state.
- Load:
  - load = 1 at an edge copies data_in and dp_in into the shadow registers at that edge.
  - Back-to-back loads are allowed; the last one wins.
  - A load does not disturb the counter or scan_idx.
- Output registers:
  - AN and SEG are registered and computed from the current scan_idx and shadow.
  - Latency is 1 clk from a scan_idx or shadow change to the pins.
  - The first edge after reset release drives digit 0: AN = 8'hFE.
- Lit slot (digit_en[scan_idx] = 1):
  - AN = ~(8'h01 << scan_idx)
  - SEG[6:0] = decode of the shadow nibble
  - SEG[7] = ~dp_shadow[scan_idx]
- Blanked slot (digit_en[scan_idx] = 0):
  - The time slot is still consumed, to keep brightness uniform.
  - AN = 8'hFF, SEG = 8'hFF.
- Decode table, SEG[6:0] as hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Reset mid-scan: outputs are blanked immediately (asynchronously). Scanning restarts at digit 0 with a full SCAN_DIV dwell.
- Simultaneous load and slot change: the new digit shows the new shadow value one clk later, at the normal 1-clk latency.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most-significant nonzero shadow nibble are blanked (AN = 8'hFF, SEG = 8'hFF) even when enabled.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
  - A digit whose dp_shadow bit is set is also not blanked by this rule.
  - digit_en still applies on top.
  - The MSB search is combinational on the shadow; latency stays 1 clk.
- Undefined: every enabled digit shows its nibble, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - NUM_DIGITS = 8
  - SEG_BLANK = 8'hFF, AN_OFF = 8'hFF
  - 16-entry segment pattern constant array
  - typedef for the digit index (3 bits)
- Sub-module seg7_hex_decode: purely combinational, 4-bit nibble -> 7-bit active-low pattern. Instantiated once, muxed by scan_idx.

Test Plan:
- Reset and first digit:
  - Hold rst_n = 0 for 5 clk: AN = FF, SEG = FF.
  - Release: 1 clk later AN = FE, SEG = C0 (digit 0 of value 0).
- Scan order and value (SCAN_DIV = 4, load 32'h12345678, dp_in = 0, digit_en = FF):
  - AN steps FE, FD, FB, ... 7F, each held 4 clk, then wraps to FE.
  - SEG per digit: F8, 82, 92, 99, B0, A4, F9, C0 is incorrect ordering guard; expected digit 0..7 = 80, F8, 82, 92, 99, B0, A4, F9.
- Mid-scan load and DP:
  - During digit 3, load 32'hFFFFFFFF with dp_in = 08.
  - Next clk SEG = 0E (DP lit on digit 3); other digits show 8E.
- Enable mask:
  - digit_en = 0F with value 32'hABCD0123.
  - Digits 4..7 give AN = FF and SEG = FF for their full slots; digits 0..3 show A4, 30, F9, C0 is wrong; expected digit 0..3 = B0, A4, F9, C0.
- Leading-zero blank (macro defined):
  - Value 32'h00000A05: only digits 0..2 light (92, C0, 88); digits 3..7 are blanked.
  - Value 0: only digit 0 lights, showing C0.
- Async reset mid-scan: assert rst_n between edges during digit 5 -> AN = FF immediately; after release, digit 0 is driven with a full 4-clk dwell.
